entropy_feeder: RTL

//  Producer side of the 1-bit entropy input of prng_wrap. Harvests raw noise bits,

---
 rtl/entropy_feeder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/entropy_feeder.sv
// Von Neumann-whitened entropy pool feeding the 1-bit entropy input of prng_wrap.
// Optional raw-bit bypass of the extractor via `define ENTROPY_FEEDER_BYPASS_EN.
module entropy_feeder #(
    parameter int unsigned SOURCES       = 4,
    parameter int unsigned POOL_BITS     = 16,
    parameter int unsigned INJECT_PERIOD = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [SOURCES-1:0]                 noise,
    input  logic                               noise_valid,
`ifdef ENTROPY_FEEDER_BYPASS_EN
    input  logic                               bypass_debias,
`endif
    input  logic                               overflow_clr,
    output logic                               entropy,
    output logic [$clog2(POOL_BITS+1)-1:0]     pool_level,
    output logic                               pool_full,
    output logic                               overflow,
    output logic                               starved
);

    localparam int unsigned LVL_W = $clog2(POOL_BITS + 1);
    localparam int unsigned PTR_W = $clog2(POOL_BITS);
    localparam int unsigned CNT_W = $clog2(INJECT_PERIOD);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HALF = 1'b1
    } ext_state_t;

    ext_state_t         state, state_nxt;
    logic               b0, b0_nxt;
    logic               raw_c;
    logic               bypass_c;
    logic               push_c;
    logic               push_bit_c;

    logic [POOL_BITS-1:0] mem;
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [LVL_W-1:0]     level_nxt;
    logic [CNT_W-1:0]     slot_cnt;
    logic                 tick_c, pop_c, full_c, wr_en_c, drop_c;

`ifdef ENTROPY_FEEDER_BYPASS_EN
    assign bypass_c = bypass_debias;
`else
    assign bypass_c = 1'b0;
`endif

    assign raw_c = ^noise;

    // Extractor state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            b0    <= 1'b0;
        end else begin
            state <= state_nxt;
            b0    <= b0_nxt;
        end
    end

    // Extractor next state: pairs of unequal raw bits emit their first bit
    always_comb begin
        state_nxt  = state;
        b0_nxt     = b0;
        push_c     = 1'b0;
        push_bit_c = b0;
        if (noise_valid) begin
            if (bypass_c) begin
                state_nxt  = S_IDLE;
                push_c     = 1'b1;
                push_bit_c = raw_c;
            end else begin
                case (state)
                    S_IDLE: begin
                        state_nxt = S_HALF;
                        b0_nxt    = raw_c;
                    end
                    S_HALF: begin
                        state_nxt = S_IDLE;
                        push_c    = (b0 != raw_c);
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
        end
    end

    assign tick_c  = (slot_cnt == CNT_W'(INJECT_PERIOD - 1));
    assign pop_c   = tick_c && (pool_level != '0);
    assign full_c  = (pool_level == LVL_W'(POOL_BITS));
    // A pop frees the slot in the same cycle, so a push into a full pool survives
    assign wr_en_c = push_c && (!full_c || pop_c);
    assign drop_c  = push_c && full_c && !pop_c;

    always_comb begin
        level_nxt = pool_level;
        if (wr_en_c && !pop_c) begin
            level_nxt = pool_level + LVL_W'(1);
        end else if (pop_c && !wr_en_c) begin
            level_nxt = pool_level - LVL_W'(1);
        end
    end

    // Pool storage, pointers and injection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pool_level <= '0;
            pool_full  <= 1'b0;
            entropy    <= 1'b0;
            slot_cnt   <= '0;
        end else begin
            if (wr_en_c) begin
                mem[wr_ptr] <= push_bit_c;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            entropy    <= pop_c ? mem[rd_ptr] : 1'b0;
            pool_level <= level_nxt;
            pool_full  <= (level_nxt == LVL_W'(POOL_BITS));
            slot_cnt   <= tick_c ? '0 : slot_cnt + CNT_W'(1);
        end
    end

    // Sticky flags: a same-cycle set beats the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            starved  <= 1'b0;
        end else begin
            if (drop_c) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
            if (tick_c && (pool_level == '0)) begin
                starved <= 1'b1;
            end else if (overflow_clr) begin
                starved <= 1'b0;
            end
        end
    end

endmodule
